uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter with an internal transmit FIFO; the TX-direction counterpart of the existing UART receiver block.
- Host side pushes bytes through a write-enable / full handshake on the system clock.
- Block serialises each byte onto the line as an 11-bit frame: start, 8 data bits LSB-first, parity, stop. The receiver expects exactly this frame.
- The baud rate is derived internally from clk, so no separate baud clock is required.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2 or more.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2 or more.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- wr_en  input  1  push data_in into the FIFO this cycle.
- tx_full  output  1  FIFO holds FIFO_DEPTH entries.
- tx_empty  output  1  FIFO holds 0 entries.
- overflow  output  1  one-cycle pulse when a push is dropped.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (rst sampled high at posedge):
  - tx=1, tx_busy=0, tx_full=0, tx_empty=1, overflow=0.
  - FIFO pointers and count cleared; FSM to IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame; tx is 1 on the following cycle. No partial frame resumes.
- Push:
  - wr_en && !tx_full: data_in written at that edge; count+1.
  - wr_en && tx_full: write dropped and overflow=1 for one cycle. This holds even if an internal pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- FIFO flags:
  - Registered; derived from the post-edge count.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If !tx_empty: pop head into an 8-bit shift register, compute parity, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit_idx=7 go to PARITY.
  - PARITY: tx = ^byte XOR PARITY_ODD, held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - if FIFO is non-empty: pop and go directly to START (zero idle gap between frames);
    - otherwise go to IDLE.
- Outputs registered:
  - tx is a flop output, glitch-free.
  - tx_busy=1 in START, DATA, PARITY, STOP.
- Latency and timing:
  - wr_en at edge N into an empty, idle block: pop at edge N+1; tx goes low after edge N+2.
  - Each frame lasts exactly 11*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, reset to 0 on each state entry.
- Byte capture: writes while a frame is in flight never disturb the shift register.

Decomposition:
- uart_pkg, shared with the receiver:
  - UART_FRAME_W=11, UART_DATA_W=8;
  - the tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - function parity_bit(byte, odd).
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, full, empty, rdata.
  - Combinational read of the head entry.
  - Registered flags.
  - Reused later for the RX FIFO.
- uart_tx contains the baud counter, the FSM and the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, PARITY_ODD=0):
- Single byte: push 0xA5 while idle -> tx sequence 0,1,0,1,0,0,1,0,1,0,1 with each bit 4 cycles wide; tx low begins 2 cycles after the push edge; tx_busy high for exactly 44 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two frames with no idle gap.
  - Frame 1 is 0, eight 0s, parity 0, stop 1.
  - Frame 2 is 0, eight 1s, parity 0, stop 1.
  - Total busy time is 88 cycles.
- Full/overflow: while a frame is on the line, push 4 bytes -> tx_full=1. A 5th push gives overflow=1 for one cycle and is never transmitted. The remaining 4 bytes are sent in order.
- Odd parity: build with PARITY_ODD=1 and push 0x01 -> parity bit 0; push 0x03 -> parity bit 1.
- Reset mid-frame: assert rst during DATA bit 3 of 0x5A with 2 bytes queued -> next cycle tx=1, tx_busy=0, tx_empty=1; no further frames transmitted.
- Simultaneous push/pop: with FIFO count 4, push a byte on the same cycle the FSM pops -> push dropped with overflow=1, count ends at 3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit FSM states and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_FRAME_W = 11;
  localparam int UART_DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity when odd=0, odd parity when odd=1.
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data_b, input logic odd);
    return (^data_b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with combinational head read and registered full/empty/overflow flags.
// Pushes while full are dropped and flagged even if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, overflow_q;
  logic             push_ok_s, pop_ok_s;

  // Accepted push/pop and next pointer/count values; pointers wrap naturally at DEPTH.
  always_comb begin
    push_ok_s = push_i & ~full_q;
    pop_ok_s  = pop_i & ~empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
  end

  // Pointer, count and flag registers; flags follow the post-edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == {CW{1'b0}});
      overflow_q <= push_i & full_q;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data LSB-first, parity, stop.
// Line and busy outputs are flops driven from the current FSM state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   wr_en,
  output logic                   tx_full,
  output logic                   tx_empty,
  output logic                   overflow,
  output logic                   tx,
  output logic                   tx_busy
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);

  tx_state_t              state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   pop_s;
  logic                   baud_last_s;
  logic [UART_DATA_W-1:0] fifo_rdata_s;
  logic                   fifo_empty_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_en),
    .wdata_i    (data_in),
    .pop_i      (pop_s),
    .rdata_o    (fifo_rdata_s),
    .full_o     (tx_full),
    .empty_o    (fifo_empty_s),
    .overflow_o (overflow)
  );

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Next-state logic; the shift register is only loaded on a pop, so later pushes never touch it.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BW'(1'b1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pop_s     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = {BW{1'b0}};
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          shift_d  = fifo_rdata_s;
          parity_d = parity_bit(fifo_rdata_s, ODD);
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          baud_d    = {BW{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_d = {BW{1'b0}};
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty_s) begin
            pop_s    = 1'b1;
            shift_d  = fifo_rdata_s;
            parity_d = parity_bit(fifo_rdata_s, ODD);
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        baud_d  = {BW{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // Line level and busy flag decoded from the current state, registered below.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= {BW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= {UART_DATA_W{1'b0}};
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_empty = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame tables, hand sequences for FIFO/reset corners, and random traffic
// checked every cycle against a timeline model of frames and FIFO occupancy.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int FW = 11;

  logic       clk = 1'b0;
  logic       rst, wr_e, wr_o;
  logic [7:0] din;
  logic       tx_e, busy_e, full_e, empty_e, ovf_e;
  logic       tx_o, busy_o, full_o, empty_o, ovf_o;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_e),
    .tx_full(full_e), .tx_empty(empty_e), .overflow(ovf_e), .tx(tx_e), .tx_busy(busy_e)
  );

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_o),
    .tx_full(full_o), .tx_empty(empty_o), .overflow(ovf_o), .tx(tx_o), .tx_busy(busy_o)
  );

  int n_cmp, n_err, cyc;

  // Reference model for the even-parity instance: queued bytes plus the pop times of the frames.
  logic [7:0]  mq[$];
  int          end_edge, cur_pop, prev_pop;
  logic [10:0] cur_frame, prev_frame;
  logic        m_ovf;

  logic rec_tx[0:127];
  logic rec_busy[0:127];

  typedef struct {
    logic        odd_dut;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic odd);
    return {1'b1, (^b) ^ odd, b, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d, input logic r);
    int cnt;
    if (r) begin
      mq.delete();
      end_edge = 0;
      cur_pop  = -100000;
      prev_pop = -100000;
      m_ovf    = 1'b0;
    end else begin
      cnt   = mq.size();
      m_ovf = we && (cnt == D);
      if (cnt > 0 && cyc >= end_edge) begin
        prev_pop   = cur_pop;
        prev_frame = cur_frame;
        cur_pop    = cyc;
        cur_frame  = mk_frame(mq.pop_front(), 1'b0);
        end_edge   = cyc + FW * C;
      end
      if (we && cnt < D) mq.push_back(d);
    end
  endtask

  // A byte popped at edge P is on the line after edges P+1 .. P+11*C.
  task automatic model_out(output logic etx, output logic ebusy);
    int k;
    etx   = 1'b1;
    ebusy = 1'b0;
    k = cyc - 1 - cur_pop;
    if (k >= 0 && k < FW * C) begin
      etx   = cur_frame[k / C];
      ebusy = 1'b1;
    end else begin
      k = cyc - 1 - prev_pop;
      if (k >= 0 && k < FW * C) begin
        etx   = prev_frame[k / C];
        ebusy = 1'b1;
      end
    end
  endtask

  task automatic step(input logic we, input logic wo, input logic [7:0] d, input logic r);
    logic etx, ebusy;
    wr_e = we; wr_o = wo; din = d; rst = r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_edge(we, d, r);
    model_out(etx, ebusy);
    chk("tx", {31'd0, tx_e}, {31'd0, etx});
    chk("tx_busy", {31'd0, busy_e}, {31'd0, ebusy});
    chk("tx_full", {31'd0, full_e}, {31'd0, mq.size() == D});
    chk("tx_empty", {31'd0, empty_e}, {31'd0, mq.size() == 0});
    chk("overflow", {31'd0, ovf_e}, {31'd0, m_ovf});
    wr_e = 1'b0; wr_o = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    vec_t vt[7];
    int   first_low, busy_cnt, first_b, last_b, rate;

    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; wr_e = 1'b0; wr_o = 1'b0; din = 8'h00;
    end_edge = 0; cur_pop = -100000; prev_pop = -100000; m_ovf = 1'b0;

    vt[0] = '{1'b0, 8'hA5, 11'b1_0_10100101_0};
    vt[1] = '{1'b0, 8'h00, 11'b1_0_00000000_0};
    vt[2] = '{1'b0, 8'hFF, 11'b1_0_11111111_0};
    vt[3] = '{1'b0, 8'h80, 11'b1_1_10000000_0};
    vt[4] = '{1'b0, 8'h5A, 11'b1_0_01011010_0};
    vt[5] = '{1'b1, 8'h01, 11'b1_0_00000001_0};
    vt[6] = '{1'b1, 8'h03, 11'b1_1_00000011_0};

    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_tx_odd", {31'd0, tx_o}, 32'd1);
    chk("reset_empty_odd", {31'd0, empty_o}, 32'd1);
    idle(2);

    // Single frames while idle, on either instance.
    for (int v = 0; v < 7; v++) begin
      step(~vt[v].odd_dut, vt[v].odd_dut, vt[v].data, 1'b0);
      rec_tx[0]   = vt[v].odd_dut ? tx_o : tx_e;
      rec_busy[0] = vt[v].odd_dut ? busy_o : busy_e;
      for (int j = 1; j < 60; j++) begin
        step(1'b0, 1'b0, 8'h00, 1'b0);
        rec_tx[j]   = vt[v].odd_dut ? tx_o : tx_e;
        rec_busy[j] = vt[v].odd_dut ? busy_o : busy_e;
      end
      first_low = -1; busy_cnt = 0;
      for (int j = 0; j < 60; j++) begin
        if (first_low < 0 && rec_tx[j] == 1'b0) first_low = j;
        if (rec_busy[j]) busy_cnt++;
      end
      chk("start_latency", first_low, 32'd2);
      chk("busy_cycles", busy_cnt, FW * C);
      for (int k = 0; k < FW; k++)
        for (int s = 0; s < C; s++)
          chk($sformatf("frame%0d_bit%0d", v, k), {31'd0, rec_tx[2 + k * C + s]}, {31'd0, vt[v].frame[k]});
      chk("idle_after_frame", {31'd0, rec_tx[59]}, 32'd1);
    end

    // Back-to-back 0x00 then 0xFF: no gap between frames.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rec_tx[0] = tx_e; rec_busy[0] = busy_e;
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    rec_tx[1] = tx_e; rec_busy[1] = busy_e;
    for (int j = 2; j < 110; j++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      rec_tx[j] = tx_e; rec_busy[j] = busy_e;
    end
    busy_cnt = 0; first_b = -1; last_b = -1;
    for (int j = 0; j < 110; j++) begin
      if (rec_busy[j]) begin
        busy_cnt++;
        if (first_b < 0) first_b = j;
        last_b = j;
      end
    end
    chk("b2b_busy_cycles", busy_cnt, 32'd88);
    chk("b2b_busy_span", last_b - first_b + 1, 32'd88);
    chk("b2b_stop1", {31'd0, rec_tx[45]}, 32'd1);
    chk("b2b_start2", {31'd0, rec_tx[46]}, 32'd0);
    chk("b2b_data2_lsb", {31'd0, rec_tx[50]}, 32'd1);
    chk("b2b_parity2", {31'd0, rec_tx[82]}, 32'd0);

    // Fill the FIFO during a frame, overflow, then push exactly on the chaining pop edge.
    step(1'b1, 1'b0, 8'h11, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 8'h21, 1'b0);
    step(1'b1, 1'b0, 8'h32, 1'b0);
    step(1'b1, 1'b0, 8'h43, 1'b0);
    step(1'b1, 1'b0, 8'h54, 1'b0);
    chk("full_after_4", {31'd0, full_e}, 32'd1);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    chk("overflow_pulse", {31'd0, ovf_e}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("overflow_one_cycle", {31'd0, ovf_e}, 32'd0);
    for (int w = 0; w < 100 && (cyc + 1) != end_edge; w++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("full_before_pop", {31'd0, full_e}, 32'd1);
    step(1'b1, 1'b0, 8'h77, 1'b0);
    chk("pushpop_overflow", {31'd0, ovf_e}, 32'd1);
    chk("pushpop_not_full", {31'd0, full_e}, 32'd0);
    chk("pushpop_not_empty", {31'd0, empty_e}, 32'd0);
    idle(4 * FW * C + 10);
    chk("drained_empty", {31'd0, empty_e}, 32'd1);
    chk("drained_idle", {31'd0, busy_e}, 32'd0);

    // Reset during data bit 3 of 0x5A with two bytes still queued.
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    idle(16);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_mid_tx", {31'd0, tx_e}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy_e}, 32'd0);
    chk("rst_mid_empty", {31'd0, empty_e}, 32'd1);
    busy_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (busy_e || !tx_e) busy_cnt++;
    end
    chk("rst_no_resume", busy_cnt, 32'd0);

    // Random traffic with varying push rates and rare resets.
    rate = 5;
    for (int i = 0; i < 1800; i++) begin
      if (i % 300 == 0) rate = $urandom_range(1, 12);
      step($urandom_range(0, 99) < rate, 1'b0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 999) == 0);
    end
    idle(D * FW * C + 20);
    chk("final_empty", {31'd0, empty_e}, 32'd1);
    chk("final_idle_tx", {31'd0, tx_e}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
